// File: rtl/data_fifo.sv
// Synchronous data FIFO with registered pop data and a transfer-ready threshold flag.
// Define DATA_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module data_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iFlush,
  input  logic             iWriteRead,
  input  logic [AW:0]      iLevel,
  input  logic             iWrite_enable,
  input  logic [WIDTH-1:0] iData_in,
  input  logic             iRead_enable,
  output logic [WIDTH-1:0] oData_out,
  output logic             oValid,
  output logic             oFull,
  output logic             oEmpty,
  output logic [AW:0]      oCount,
  output logic             oFIFO_ok,
  output logic             oOverflow,
  output logic             oUnderflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic             ok_r;

  logic             full_s;
  logic             empty_s;
  logic             pop_s;
  logic             push_s;
  logic [AW:0]      level_s;
  logic             ok_next_s;

  // Accept decisions and the threshold comparison for the next fifo_ok value.
  always_comb begin
    full_s  = (count_r == DEPTH_C);
    empty_s = (count_r == (AW+1)'(0));
    pop_s   = iRead_enable && !empty_s;
    push_s  = iWrite_enable && (!full_s || pop_s);
    if (iLevel > DEPTH_C) begin
      level_s = DEPTH_C;
    end else begin
      level_s = iLevel;
    end
    if (iWriteRead) begin
      ok_next_s = (count_r >= level_s);
    end else begin
      ok_next_s = ((DEPTH_C - count_r) >= level_s);
    end
  end

  // Storage array; deliberately not reset or flushed.
  always_ff @(posedge iClock) begin
    if (!iReset && !iFlush && push_s) begin
      mem_r[wr_ptr_r] <= iData_in;
    end
  end

  // Pointers, occupancy, pop data register and ready flag.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
      data_r   <= WIDTH'(0);
      valid_r  <= 1'b0;
      ok_r     <= 1'b0;
    end else if (iFlush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
      valid_r  <= 1'b0;
      ok_r     <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        data_r   <= mem_r[rd_ptr_r];
      end
      valid_r <= pop_s;
      ok_r    <= ok_next_s;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef DATA_FIFO_ERR_EN
  logic ovf_r;
  logic unf_r;

  // Sticky error flags, cleared only by reset or flush.
  always_ff @(posedge iClock) begin
    if (iReset || iFlush) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (iWrite_enable && full_s && !pop_s) begin
        ovf_r <= 1'b1;
      end
      if (iRead_enable && empty_s) begin
        unf_r <= 1'b1;
      end
    end
  end

  assign oOverflow  = ovf_r;
  assign oUnderflow = unf_r;
`else
  assign oOverflow  = 1'b0;
  assign oUnderflow = 1'b0;
`endif

  assign oData_out = data_r;
  assign oValid    = valid_r;
  assign oFull     = full_s;
  assign oEmpty    = empty_s;
  assign oCount    = count_r;
  assign oFIFO_ok  = ok_r;

endmodule

// File: tb/tb_data_fifo.sv
// Scoreboard bench for data_fifo: a queue model predicts pop data and every flag each cycle.
module tb_data_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        wr_read = 1'b1;
  logic [4:0]  level = 5'd8;
  logic        we = 1'b0;
  logic [31:0] din = 32'd0;
  logic        re = 1'b0;
  logic [31:0] dout;
  logic        valid, full, empty, fifo_ok, ovf, unf;
  logic [4:0]  count;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_data = 32'd0;
  logic        ok_m = 1'b0;
  logic        ovf_m = 1'b0;
  logic        unf_m = 1'b0;
  logic        valid_m = 1'b0;

  data_fifo #(.WIDTH(32), .DEPTH(16), .AW(4)) dut (
    .iClock(clk), .iReset(rst), .iFlush(flush), .iWriteRead(wr_read), .iLevel(level),
    .iWrite_enable(we), .iData_in(din), .iRead_enable(re),
    .oData_out(dout), .oValid(valid), .oFull(full), .oEmpty(empty), .oCount(count),
    .oFIFO_ok(fifo_ok), .oOverflow(ovf), .oUnderflow(unf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int sz;
    logic [31:0] e;
    sz = model_q.size();
    check_eq("valid", {31'd0, valid}, {31'd0, valid_m});
    if (valid_m) begin
      if (exp_q.size() == 0) begin
        check_eq("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        last_data = e;
      end
    end
    check_eq("data", dout, last_data);
    check_eq("count", {27'd0, count}, sz);
    check_eq("full", {31'd0, full}, {31'd0, sz == 16});
    check_eq("empty", {31'd0, empty}, {31'd0, sz == 0});
    check_eq("fifo_ok", {31'd0, fifo_ok}, {31'd0, ok_m});
`ifdef DATA_FIFO_ERR_EN
    check_eq("overflow", {31'd0, ovf}, {31'd0, ovf_m});
    check_eq("underflow", {31'd0, unf}, {31'd0, unf_m});
`else
    check_eq("overflow", {31'd0, ovf}, 32'd0);
    check_eq("underflow", {31'd0, unf}, 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_q.delete(); exp_q.delete();
    last_data = 32'd0; ok_m = 1'b0; ovf_m = 1'b0; unf_m = 1'b0; valid_m = 1'b0;
    check_outputs();
  endtask

  task automatic step(input logic wr, input logic [31:0] d, input logic rd, input logic fl);
    int sz;
    int lvl;
    logic pop_ok, push_ok;
    we = wr; din = d; re = rd; flush = fl;
    sz = model_q.size();
    lvl = (level > 5'd16) ? 16 : int'(level);
    if (fl) begin
      model_q.delete();
      ok_m = 1'b0; ovf_m = 1'b0; unf_m = 1'b0; valid_m = 1'b0;
    end else begin
      ok_m = wr_read ? (sz >= lvl) : ((16 - sz) >= lvl);
      pop_ok = rd && (sz > 0);
      push_ok = wr && ((sz < 16) || pop_ok);
      if (wr && (sz == 16) && !pop_ok) ovf_m = 1'b1;
      if (rd && (sz == 0)) unf_m = 1'b1;
      if (pop_ok) exp_q.push_back(model_q.pop_front());
      if (push_ok) model_q.push_back(d);
      valid_m = pop_ok;
    end
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; flush = 1'b0;
    check_outputs();
  endtask

  initial begin
    do_reset();
    // fill to full, observing the threshold flag rise
    for (int n = 0; n < 16; n++) step(1'b1, 32'h1000_0000 + n, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    for (int n = 0; n < 16; n++) step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    // empty: simultaneous push and pop has no fall-through
    step(1'b1, 32'h1234_5678, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    // full: simultaneous push and pop keeps count at 16
    for (int n = 0; n < 16; n++) step(1'b1, 32'h2000_0000 + n, 1'b0, 1'b0);
    step(1'b1, 32'hAAAA_5555, 1'b1, 1'b0);
    for (int n = 0; n < 16; n++) step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    // card-to-host direction, level 8 with 9 stored words
    wr_read = 1'b0;
    for (int n = 0; n < 9; n++) step(1'b1, 32'h3000_0000 + n, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    // flush restart
    wr_read = 1'b1;
    step(1'b0, 32'd0, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) step(1'b1, 32'h4000_0000 + n, 1'b0, 1'b0);
    step(1'b1, 32'h5555_0000, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    // level above depth is clamped
    level = 5'd20;
    for (int n = 0; n < 17; n++) step(1'b1, 32'h6000_0000 + n, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    // random traffic
    for (int n = 0; n < 300; n++) begin
      wr_read = 1'($urandom_range(0, 1));
      level = 5'($urandom_range(0, 20));
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           $urandom_range(0, 40) == 0);
    end
    // reset mid-transfer abandons stored words
    for (int n = 0; n < 3; n++) step(1'b1, 32'h7000_0000 + n, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 32'd0, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
